// File: rtl/shared_bus_arbiter.sv
// shared_bus_arbiter
// Round-robin arbiter that hands ownership of one shared WIDTH-bit net to one
// of NREQ requesters at a time. Every change of owner passes through a single
// turnaround cycle in which nobody drives, so two drivers never overlap. While
// nobody owns the net it is parked at IDLE_VALUE.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset
//   req      - per-requester level request
//   wdata    - requester data, slice i = wdata[i*WIDTH +: WIDTH]
//   gnt      - registered one-hot grant (all zero when nobody owns)
//   owner    - index of the current owner, meaningful while bus_oe=1
//   bus_oe   - drive enable for the shared net
//   bus_data - value for the shared net (owner data or IDLE_VALUE)
//   handoffs - count of completed grants, wraps 16'hffff -> 16'h0000
module shared_bus_arbiter #(
    parameter int                NREQ       = 4,
    parameter int                WIDTH      = 32,
    parameter int                MAX_HOLD   = 8,
    parameter logic [WIDTH-1:0]  IDLE_VALUE = WIDTH'(32'hdeadbeef)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     wdata,
    output logic [NREQ-1:0]           gnt,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      bus_oe,
    output logic [WIDTH-1:0]          bus_data,
    output logic [15:0]               handoffs
);

    localparam int OW = $clog2(NREQ);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    state_t              state_r;
    logic [NREQ-1:0]     gnt_r;
    logic [OW-1:0]       owner_r;
    logic [OW-1:0]       rr_ptr_r;
    logic [HW-1:0]       hold_cnt_r;
    logic [15:0]         handoffs_r;

    logic                win_found_s;
    logic [OW-1:0]       win_idx_s;
    logic [NREQ-1:0]     win_onehot_s;
    logic                others_s;
    logic                hold_full_s;
    logic [OW-1:0]       next_ptr_s;
    logic                release_s;
    logic [WIDTH-1:0]    slice_s [NREQ];

    // Candidate index k steps after base, wrapped modulo NREQ.
    function automatic logic [OW-1:0] cand_idx(input logic [OW-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end else begin
            sum = sum;
        end
        return sum[OW-1:0];
    endfunction

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign slice_s[g] = wdata[g*WIDTH +: WIDTH];
    end

    // Round-robin scan: walking from the far end back toward rr_ptr lets the
    // candidate closest to rr_ptr overwrite the others and win.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {OW{1'b0}};
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[cand_idx(rr_ptr_r, k)]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_idx(rr_ptr_r, k);
            end else begin
                win_found_s = win_found_s;
                win_idx_s   = win_idx_s;
            end
        end
    end

    // Ownership-release decision and pointer update for the OWN state.
    always_comb begin
        win_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << win_idx_s;
        // gnt_r holds exactly the owner bit while in OWN, so masking it
        // leaves only the competing requesters.
        others_s     = |(req & ~gnt_r);
        hold_full_s  = (hold_cnt_r >= HW'(MAX_HOLD));
        release_s    = (~req[owner_r]) | (hold_full_s & others_s);
        if (owner_r == OW'(NREQ - 1)) begin
            next_ptr_s = {OW{1'b0}};
        end else begin
            next_ptr_s = owner_r + OW'(1);
        end
    end

    // Arbitration state machine with all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            gnt_r      <= {NREQ{1'b0}};
            owner_r    <= {OW{1'b0}};
            rr_ptr_r   <= {OW{1'b0}};
            hold_cnt_r <= {HW{1'b0}};
            handoffs_r <= 16'h0000;
        end else begin
            case (state_r)
                ST_IDLE, ST_TURN: begin
                    if (win_found_s) begin
                        state_r    <= ST_OWN;
                        gnt_r      <= win_onehot_s;
                        owner_r    <= win_idx_s;
                        hold_cnt_r <= HW'(1);
                    end else begin
                        state_r    <= ST_IDLE;
                        gnt_r      <= {NREQ{1'b0}};
                    end
                end
                ST_OWN: begin
                    if (release_s) begin
                        state_r    <= ST_TURN;
                        gnt_r      <= {NREQ{1'b0}};
                        rr_ptr_r   <= next_ptr_s;
                        handoffs_r <= handoffs_r + 16'd1;
                    end else if (!hold_full_s) begin
                        hold_cnt_r <= hold_cnt_r + HW'(1);
                    end else begin
                        // Saturated: a lone requester keeps the bus forever.
                        hold_cnt_r <= hold_cnt_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= {NREQ{1'b0}};
                end
            endcase
        end
    end

    // Net drive derived from registered state only.
    always_comb begin
        bus_oe = (state_r == ST_OWN);
        if (state_r == ST_OWN) begin
            bus_data = slice_s[owner_r];
        end else begin
            bus_data = IDLE_VALUE;
        end
    end

    assign gnt      = gnt_r;
    assign owner    = owner_r;
    assign handoffs = handoffs_r;

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Self-checking bench for shared_bus_arbiter. A stimulus process drives
// directed and random request patterns, and for every cycle pushes the
// outputs a behavioural model predicts; a separate monitor pops and compares
// on the falling edge, and also checks the grant invariants.
module tb_shared_bus_arbiter;

    localparam int          NREQ     = 4;
    localparam int          WIDTH    = 32;
    localparam int          MAX_HOLD = 8;
    localparam logic [31:0] IDLE     = 32'hdeadbeef;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ*WIDTH-1:0]  wdata;
    logic [NREQ-1:0]        gnt;
    logic [1:0]             owner;
    logic                   bus_oe;
    logic [WIDTH-1:0]       bus_data;
    logic [15:0]            handoffs;

    shared_bus_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD), .IDLE_VALUE(IDLE)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .gnt(gnt),
        .owner(owner), .bus_oe(bus_oe), .bus_data(bus_data), .handoffs(handoffs)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic            oe;
        logic [1:0]      owner;
        logic [31:0]     data;
        logic [15:0]     ho;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Model: who owns the bus (-1 = nobody), for how long, where the next
    // search starts and how many grants have completed.
    int   m_owner;
    int   m_tenure;
    int   m_ptr;
    int   m_cnt;
    bit   deposit_pending = 1'b0;

    task automatic model_reset();
        m_owner  = -1;
        m_tenure = 0;
        m_ptr    = 0;
        m_cnt    = 0;
    endtask

    task automatic model_next(input logic r, input logic [NREQ-1:0] rq);
        bit others;
        bit found;
        if (r) begin
            model_reset();
        end else if (m_owner >= 0) begin
            others = 1'b0;
            for (int i = 0; i < NREQ; i++)
                if (i != m_owner && rq[i]) others = 1'b1;
            if (!rq[m_owner] || (m_tenure >= MAX_HOLD && others)) begin
                m_cnt   = (m_cnt + 1) % 65536;
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
            end else begin
                m_tenure++;
            end
        end else begin
            found = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                int c;
                c = (m_ptr + i) % NREQ;
                if (!found && rq[c]) begin
                    found    = 1'b1;
                    m_owner  = c;
                    m_tenure = 1;
                end
            end
        end
    endtask

    // One clock of stimulus: apply inputs, record the expected outputs for
    // this cycle, then advance the model across the coming edge.
    task automatic step(input logic r, input logic [NREQ-1:0] rq,
                        input logic [NREQ*WIDTH-1:0] wd);
        exp_t e;
        @(posedge clk);
        #1;
        if (deposit_pending) begin
            dut.handoffs_r  = 16'hfffd;
            m_cnt           = 16'hfffd;
            deposit_pending = 1'b0;
        end
        rst   = r;
        req   = rq;
        wdata = wd;
        e.oe  = (m_owner >= 0);
        if (m_owner >= 0) begin
            e.gnt   = 4'b0001 << m_owner;
            e.owner = m_owner[1:0];
            e.data  = wd[m_owner*WIDTH +: WIDTH];
        end else begin
            e.gnt   = 4'b0000;
            e.owner = 2'd0;
            e.data  = IDLE;
        end
        e.ho = m_cnt[15:0];
        exp_q.push_back(e);
        model_next(r, rq);
    endtask

    function automatic logic [NREQ*WIDTH-1:0] rnd_wd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: compares every recorded cycle and checks the grant invariants.
    initial begin
        exp_t            e;
        logic [NREQ-1:0] prev;
        prev = '0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (gnt !== e.gnt || bus_oe !== e.oe || bus_data !== e.data ||
                    handoffs !== e.ho || (e.oe && owner !== e.owner)) begin
                    n_err++;
                    $display("FAIL snapshot t=%0t gnt=%b exp %b oe=%b exp %b owner=%0d exp %0d data=%h exp %h handoffs=%h exp %h",
                             $time, gnt, e.gnt, bus_oe, e.oe, owner, e.owner,
                             bus_data, e.data, handoffs, e.ho);
                end
                n_cmp++;
                if ($countones(gnt) > 1) begin
                    n_err++;
                    $display("FAIL onehot t=%0t gnt=%b required zero or one-hot", $time, gnt);
                end
                n_cmp++;
                if (bus_oe !== (|gnt)) begin
                    n_err++;
                    $display("FAIL oe_vs_gnt t=%0t bus_oe=%b required %b", $time, bus_oe, |gnt);
                end
                n_cmp++;
                if (prev != '0 && gnt != '0 && gnt != prev) begin
                    n_err++;
                    $display("FAIL no_turnaround t=%0t gnt %b -> %b required a zero cycle between",
                             $time, prev, gnt);
                end
                prev = gnt;
            end
        end
    end

    // Stimulus sequence.
    initial begin
        logic [NREQ*WIDTH-1:0] wd;
        logic [NREQ-1:0]       cur;
        logic                  r;
        rst   = 1'b1;
        req   = '0;
        wdata = '0;
        model_reset();

        step(1'b1, 4'b0000, '0);
        step(1'b1, 4'b0000, '0);
        repeat (5) step(1'b0, 4'b0000, rnd_wd());

        // Single requester 2, then release.
        wd = rnd_wd();
        wd[2*WIDTH +: WIDTH] = 32'h12345678;
        repeat (3) step(1'b0, 4'b0100, wd);
        repeat (3) step(1'b0, 4'b0000, wd);

        // Everyone requesting: rotation with preemption after MAX_HOLD.
        repeat (50) step(1'b0, 4'b1111, rnd_wd());
        repeat (3) step(1'b0, 4'b0000, rnd_wd());

        // Lone requester keeps the bus.
        repeat (22) step(1'b0, 4'b0010, rnd_wd());
        repeat (3) step(1'b0, 4'b0000, rnd_wd());

        // Reset in the middle of an ownership.
        repeat (4) step(1'b0, 4'b0001, rnd_wd());
        step(1'b1, 4'b0001, rnd_wd());
        repeat (3) step(1'b0, 4'b0001, rnd_wd());
        repeat (2) step(1'b0, 4'b0000, rnd_wd());

        // Random traffic with slowly changing requests and rare resets.
        cur = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < NREQ; b++)
                if ($urandom_range(5, 0) == 0) cur[b] = ~cur[b];
            r = ($urandom_range(399, 0) == 0);
            step(r, cur, rnd_wd());
        end

        // Counter wrap: preload near the top, then back-to-back grants.
        step(1'b1, 4'b0000, '0);
        step(1'b0, 4'b0000, rnd_wd());
        deposit_pending = 1'b1;
        step(1'b0, 4'b0000, rnd_wd());
        for (int n = 0; n < 10; n++)
            step(1'b0, (n % 2 == 0) ? 4'b0001 : 4'b0000, rnd_wd());
        repeat (3) step(1'b0, 4'b0000, rnd_wd());

        @(posedge clk);
        @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain pending=%0d required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
